mega_mul_seq: RTL and testbench

MEGA_MUL_SEQ -- requirements
Module: mega_mul_seq

---
 rtl/mega_mul_pkg.sv | 31 +++
 rtl/mega_mul_step.sv | 42 ++++
 rtl/mega_mul_seq.sv | 186 ++++++++++++++++++
 tb/tb_mega_mul_seq.sv | 210 +++++++++++++++++++++
 4 files changed

// File: rtl/mega_mul_pkg.sv
// ----------------------------------------------------------------------------
// mega_mul_pkg
// Shared definitions for the sequential multiplier: FSM state encoding,
// the mode-field layout and encodings, and the status-register bit indices
// that the multiplier rewrites.
// ----------------------------------------------------------------------------
package mega_mul_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    // mode = {frac, sign_b, sign_a}
    localparam int MODE_SIGN_A = 0;
    localparam int MODE_SIGN_B = 1;
    localparam int MODE_FRAC   = 2;

    localparam logic [2:0] MODE_MUL    = 3'b000;
    localparam logic [2:0] MODE_MULSU  = 3'b001;
    localparam logic [2:0] MODE_MULS   = 3'b011;
    localparam logic [2:0] MODE_FMUL   = 3'b100;
    localparam logic [2:0] MODE_FMULSU = 3'b101;
    localparam logic [2:0] MODE_FMULS  = 3'b111;

    // Status-register flags replaced by the multiplier
    localparam int SREG_C = 0;
    localparam int SREG_Z = 1;

endpackage

// File: rtl/mega_mul_step.sv
// ----------------------------------------------------------------------------
// mega_mul_step
// One combinational shift-add step: retires BITS_PER_CYCLE multiplier bits
// (LSB first) into the accumulator, then advances the multiplicand and
// multiplier by BITS_PER_CYCLE positions.
//
// Ports
//   acc         in  2*WIDTH   running partial product
//   mcand       in  2*WIDTH   multiplicand magnitude, pre-shifted
//   mplier      in  WIDTH+1   remaining multiplier magnitude bits
//   acc_next    out 2*WIDTH   accumulator after this step
//   mcand_next  out 2*WIDTH   multiplicand shifted left by BITS_PER_CYCLE
//   mplier_next out WIDTH+1   multiplier shifted right by BITS_PER_CYCLE
// ----------------------------------------------------------------------------
module mega_mul_step
    import mega_mul_pkg::*;
#(
    parameter int WIDTH          = 8,
    parameter int BITS_PER_CYCLE = 1
) (
    input  logic [2*WIDTH-1:0] acc,
    input  logic [2*WIDTH-1:0] mcand,
    input  logic [WIDTH:0]     mplier,
    output logic [2*WIDTH-1:0] acc_next,
    output logic [2*WIDTH-1:0] mcand_next,
    output logic [WIDTH:0]     mplier_next
);

    // The accumulator is only 2*WIDTH wide; bits shifted beyond it are
    // dropped, which is harmless because the final magnitude always fits.
    always_comb begin
        acc_next = acc;
        for (int i = 0; i < BITS_PER_CYCLE; i++) begin
            if (mplier[i]) begin
                acc_next = acc_next + (mcand << i);
            end
        end
        mcand_next  = mcand << BITS_PER_CYCLE;
        mplier_next = mplier >> BITS_PER_CYCLE;
    end

endmodule

// File: rtl/mega_mul_seq.sv
// ----------------------------------------------------------------------------
// mega_mul_seq
// Sequential signed/unsigned (optionally fractional) multiplier with an
// IDLE -> RUN -> DONE handshake. Operands are converted to magnitudes when
// accepted, multiplied by iterative shift-add and the sign is restored in
// DONE. Latency from the accepting edge to done is WIDTH/BITS_PER_CYCLE + 1.
//
// Ports
//   clk       in   1        clock, rising edge
//   rst       in   1        asynchronous active-high reset
//   start     in   1        request, sampled only in IDLE
//   abort     in   1        cancel an operation in RUN
//   mode      in   3        {frac, sign_b, sign_a}
//   rd        in   WIDTH    multiplicand A
//   rr        in   WIDTH    multiplier B
//   sreg_in   in   8        status register in
//   R         out  2*WIDTH  product (registered)
//   sreg_out  out  8        sreg_in with C/Z replaced (registered)
//   busy      out  1        high in RUN and DONE
//   done      out  1        one-cycle pulse, R/sreg_out valid
//
// Configuration macro: MEGA_MUL_SEQ_FRAC_EN enables the fractional modes;
// without it mode[2] has no effect.
// ----------------------------------------------------------------------------
module mega_mul_seq
    import mega_mul_pkg::*;
#(
    parameter int WIDTH          = 8,
    parameter int BITS_PER_CYCLE = 1
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               start,
    input  logic               abort,
    input  logic [2:0]         mode,
    input  logic [WIDTH-1:0]   rd,
    input  logic [WIDTH-1:0]   rr,
    input  logic [7:0]         sreg_in,
    output logic [2*WIDTH-1:0] R,
    output logic [7:0]         sreg_out,
    output logic               busy,
    output logic               done
);

    localparam int STEPS = WIDTH / BITS_PER_CYCLE;
    localparam int CW    = $clog2(STEPS + 1);
    localparam logic [CW-1:0] LAST_STEP = CW'(STEPS - 1);

    state_t state;
    state_t state_next;

    logic [CW-1:0]      cnt;
    logic [2*WIDTH-1:0] acc;
    logic [2*WIDTH-1:0] mcand;
    logic [WIDTH:0]     mplier;
    logic               neg;
    logic               frac;
    logic [5:0]         sreg_hi;

    logic               accept;
    logic               step_en;
    logic               finish;

    logic [2*WIDTH-1:0] acc_next;
    logic [2*WIDTH-1:0] mcand_next;
    logic [WIDTH:0]     mplier_next;

    // Encodings 010/110 behave like 011/111, so sign_b implies sign_a.
    logic               sign_a;
    logic               sign_b;
    logic               a_neg;
    logic               b_neg;
    logic [WIDTH:0]     a_ext;
    logic [WIDTH:0]     b_ext;
    logic [WIDTH:0]     a_mag;
    logic [WIDTH:0]     b_mag;
    logic               frac_sel;

    assign sign_a = mode[MODE_SIGN_A] | mode[MODE_SIGN_B];
    assign sign_b = mode[MODE_SIGN_B];
    assign a_neg  = sign_a & rd[WIDTH-1];
    assign b_neg  = sign_b & rr[WIDTH-1];
    assign a_ext  = {a_neg, rd};
    assign b_ext  = {b_neg, rr};

    // WIDTH+1 bits so the most-negative operand has a representable magnitude
    assign a_mag = a_neg ? (~a_ext + 1'b1) : a_ext;
    assign b_mag = b_neg ? (~b_ext + 1'b1) : b_ext;

`ifdef MEGA_MUL_SEQ_FRAC_EN
    assign frac_sel = mode[MODE_FRAC];
`else
    logic unused_frac;
    assign unused_frac = mode[MODE_FRAC];
    assign frac_sel    = 1'b0;
`endif

    mega_mul_step #(
        .WIDTH          (WIDTH),
        .BITS_PER_CYCLE (BITS_PER_CYCLE)
    ) u_step (
        .acc         (acc),
        .mcand       (mcand),
        .mplier      (mplier),
        .acc_next    (acc_next),
        .mcand_next  (mcand_next),
        .mplier_next (mplier_next)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= ST_IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        case (state)
            ST_IDLE: if (start && !abort) state_next = ST_RUN;
            ST_RUN: begin
                if (abort) begin
                    state_next = ST_IDLE;
                end else if (cnt == LAST_STEP) begin
                    state_next = ST_DONE;
                end
            end
            ST_DONE: state_next = ST_IDLE;
            default: state_next = ST_IDLE;
        endcase
    end

    always_comb begin
        busy    = (state != ST_IDLE);
        accept  = (state == ST_IDLE) && start && !abort;
        step_en = (state == ST_RUN) && !abort;
        finish  = (state == ST_DONE);
    end

    // Sign restoration and optional fractional shift of the final product
    logic [2*WIDTH-1:0] p_signed;
    logic [2*WIDTH-1:0] r_val;

    always_comb begin
        p_signed = neg ? (~acc + 1'b1) : acc;
        r_val    = frac ? (p_signed << 1) : p_signed;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt      <= '0;
            acc      <= '0;
            mcand    <= '0;
            mplier   <= '0;
            neg      <= 1'b0;
            frac     <= 1'b0;
            sreg_hi  <= '0;
            R        <= '0;
            sreg_out <= '0;
            done     <= 1'b0;
        end else begin
            done <= finish;
            if (accept) begin
                cnt     <= '0;
                acc     <= '0;
                mcand   <= {{(WIDTH-1){1'b0}}, a_mag};
                mplier  <= b_mag;
                neg     <= a_neg ^ b_neg;
                frac    <= frac_sel;
                sreg_hi <= sreg_in[7:2];
            end
            if (step_en) begin
                cnt    <= cnt + 1'b1;
                acc    <= acc_next;
                mcand  <= mcand_next;
                mplier <= mplier_next;
            end
            if (finish) begin
                R        <= r_val;
                sreg_out <= {sreg_hi, (r_val == '0), p_signed[2*WIDTH-1]};
            end
        end
    end

endmodule

// File: tb/tb_mega_mul_seq.sv
// ----------------------------------------------------------------------------
// tb_mega_mul_seq
// Scoreboard bench for two multiplier instances (WIDTH=8/BPC=1 and
// WIDTH=16/BPC=4). Stimulus pushes hand-computed results into per-instance
// queues; monitors pop and compare whenever done pulses.
// ----------------------------------------------------------------------------
module tb_mega_mul_seq;
    import mega_mul_pkg::*;

    typedef struct {
        logic [63:0] r;
        logic [7:0]  s;
        int          acc;
        int          lat;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst8, rst16;
    logic        start8, abort8, start16, abort16;
    logic [2:0]  mode8, mode16;
    logic [7:0]  rd8, rr8;
    logic [15:0] rd16, rr16;
    logic [7:0]  sin8, sin16;
    logic [15:0] r8;
    logic [31:0] r16;
    logic [7:0]  sout8, sout16;
    logic        busy8, done8, busy16, done16;

    exp_t q8[$];
    exp_t q16[$];
    exp_t e8, e16;
    int   errors = 0;
    int   checks = 0;
    int   cyc = 0;

    mega_mul_seq #(.WIDTH(8), .BITS_PER_CYCLE(1)) dut8 (
        .clk(clk), .rst(rst8), .start(start8), .abort(abort8), .mode(mode8),
        .rd(rd8), .rr(rr8), .sreg_in(sin8), .R(r8), .sreg_out(sout8),
        .busy(busy8), .done(done8)
    );

    mega_mul_seq #(.WIDTH(16), .BITS_PER_CYCLE(4)) dut16 (
        .clk(clk), .rst(rst16), .start(start16), .abort(abort16), .mode(mode16),
        .rd(rd16), .rr(rr16), .sreg_in(sin16), .R(r16), .sreg_out(sout16),
        .busy(busy16), .done(done16)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check_output(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("[TB] FAIL %s: got 0x%0h, want 0x%0h", name, act, exp);
        end
    endtask

    // Scoreboard monitors: any done pulse must match the oldest expectation
    always @(negedge clk) begin
        if (done8) begin
            if (q8.size() == 0) begin
                check_output("w8_unexpected_done", 64'd1, 64'd0);
            end else begin
                e8 = q8.pop_front();
                check_output("w8_R", {48'b0, r8}, e8.r);
                check_output("w8_sreg", {56'b0, sout8}, {56'b0, e8.s});
                check_output("w8_latency", 64'(cyc - e8.acc), 64'(e8.lat));
            end
        end
    end

    always @(negedge clk) begin
        if (done16) begin
            if (q16.size() == 0) begin
                check_output("w16_unexpected_done", 64'd1, 64'd0);
            end else begin
                e16 = q16.pop_front();
                check_output("w16_R", {32'b0, r16}, e16.r);
                check_output("w16_sreg", {56'b0, sout16}, {56'b0, e16.s});
                check_output("w16_latency", 64'(cyc - e16.acc), 64'(e16.lat));
            end
        end
    end

    task automatic wait_done(input int unit);
        bit seen = 1'b0;
        for (int i = 0; i < 40 && !seen; i++) begin
            @(negedge clk);
            seen = (unit == 8) ? done8 : done16;
        end
        check_output(unit == 8 ? "w8_done_timeout" : "w16_done_timeout", 64'(seen), 64'd1);
    endtask

    // Issue one operation; inputs are scrambled right after acceptance so a
    // design that fails to latch them produces a wrong product.
    task automatic apply_stimulus(input int unit, input logic [2:0] m,
                                  input logic [15:0] a, input logic [15:0] b,
                                  input logic [7:0] s, input logic [63:0] er,
                                  input logic [7:0] es, input int hold,
                                  input bit expect_done);
        exp_t e;
        @(negedge clk);
        if (unit == 8) begin
            start8 = 1'b1; mode8 = m; rd8 = a[7:0]; rr8 = b[7:0]; sin8 = s;
        end else begin
            start16 = 1'b1; mode16 = m; rd16 = a; rr16 = b; sin16 = s;
        end
        @(posedge clk);
        #1;
        check_output(unit == 8 ? "w8_accept_busy" : "w16_accept_busy",
                     64'(unit == 8 ? busy8 : busy16), 64'd1);
        if (expect_done) begin
            e.r = er; e.s = es; e.acc = cyc; e.lat = (unit == 8) ? 9 : 5;
            if (unit == 8) q8.push_back(e);
            else q16.push_back(e);
        end
        if (unit == 8) begin
            mode8 = 3'($urandom); rd8 = 8'($urandom); rr8 = 8'($urandom); sin8 = 8'($urandom);
        end else begin
            mode16 = 3'($urandom); rd16 = 16'($urandom); rr16 = 16'($urandom); sin16 = 8'($urandom);
        end
        repeat (hold) @(negedge clk);
        start8  = (unit == 8)  ? 1'b0 : start8;
        start16 = (unit == 16) ? 1'b0 : start16;
        if (expect_done) wait_done(unit);
    endtask

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation did not complete");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        rst8 = 1'b0; rst16 = 1'b0;
        start8 = 1'b0; abort8 = 1'b0; mode8 = '0; rd8 = '0; rr8 = '0; sin8 = '0;
        start16 = 1'b0; abort16 = 1'b0; mode16 = '0; rd16 = '0; rr16 = '0; sin16 = '0;
        #1;
        rst8 = 1'b1; rst16 = 1'b1;
        #1;
        check_output("rst_R8", {48'b0, r8}, 64'd0);
        check_output("rst_sreg8", {56'b0, sout8}, 64'd0);
        check_output("rst_busy_done8", {62'b0, busy8, done8}, 64'd0);
        check_output("rst_R16", {32'b0, r16}, 64'd0);
        check_output("rst_busy_done16", {62'b0, busy16, done16}, 64'd0);
        repeat (3) @(negedge clk);
        rst8 = 1'b0; rst16 = 1'b0;

        // WIDTH=8 directed vectors
        apply_stimulus(8, MODE_MUL,   16'h00FF, 16'h00FF, 8'h00, 64'hFE01, 8'h01, 0, 1'b1);
        apply_stimulus(8, MODE_MULS,  16'h0080, 16'h0080, 8'h00, 64'h4000, 8'h00, 0, 1'b1);
        apply_stimulus(8, MODE_MULSU, 16'h00FF, 16'h0002, 8'h00, 64'hFFFE, 8'h01, 0, 1'b1);
`ifdef MEGA_MUL_SEQ_FRAC_EN
        apply_stimulus(8, MODE_FMULSU, 16'h00C0, 16'h0080, 8'h00, 64'hC000, 8'h01, 0, 1'b1);
        apply_stimulus(8, MODE_FMULS,  16'h0040, 16'h0040, 8'h00, 64'h2000, 8'h00, 0, 1'b1);
`else
        apply_stimulus(8, MODE_FMULSU, 16'h00C0, 16'h0080, 8'h00, 64'hE000, 8'h01, 0, 1'b1);
        apply_stimulus(8, MODE_FMULS,  16'h0040, 16'h0040, 8'h00, 64'h1000, 8'h00, 0, 1'b1);
`endif
        apply_stimulus(8, 3'b010,    16'h00FE, 16'h0003, 8'h00, 64'hFFFA, 8'h01, 0, 1'b1);
        apply_stimulus(8, MODE_MUL,  16'h0000, 16'h0037, 8'hAB, 64'h0000, 8'hAA, 0, 1'b1);
        // start held high through part of RUN must not restart the operation
        apply_stimulus(8, MODE_MUL,  16'h00FF, 16'h00FF, 8'h00, 64'hFE01, 8'h01, 4, 1'b1);

        // Abort in the third RUN cycle with start still held
        @(negedge clk);
        start8 = 1'b1; mode8 = MODE_MUL; rd8 = 8'h12; rr8 = 8'h34; sin8 = 8'h00;
        @(posedge clk);
        @(posedge clk);
        @(posedge clk);
        @(negedge clk);
        abort8 = 1'b1;
        @(posedge clk);
        #1;
        check_output("abort_busy", 64'(busy8), 64'd0);
        check_output("abort_done", 64'(done8), 64'd0);
        check_output("abort_R_hold", {48'b0, r8}, 64'hFE01);
        @(posedge clk);
        #1;
        check_output("abort_priority_busy", 64'(busy8), 64'd0);
        @(negedge clk);
        abort8 = 1'b0; start8 = 1'b0;
        repeat (12) @(negedge clk);
        apply_stimulus(8, MODE_MULS, 16'h007F, 16'h0081, 8'h00, 64'hC0FF, 8'h01, 0, 1'b1);

        // WIDTH=16, BITS_PER_CYCLE=4
        apply_stimulus(16, MODE_MUL, 16'hFFFF, 16'hFFFF, 8'h00, 64'hFFFE0001, 8'h01, 0, 1'b1);
        apply_stimulus(16, MODE_MUL, 16'h00FF, 16'h0101, 8'h00, 64'h0, 8'h00, 0, 1'b0);
        @(posedge clk);
        #2;
        rst16 = 1'b1;
        #1;
        check_output("midrun_rst_R16", {32'b0, r16}, 64'd0);
        check_output("midrun_rst_sreg16", {56'b0, sout16}, 64'd0);
        check_output("midrun_rst_busy_done16", {62'b0, busy16, done16}, 64'd0);
        @(negedge clk);
        rst16 = 1'b0;
        apply_stimulus(16, MODE_MUL,  16'h1234, 16'h0010, 8'hFF, 64'h00012340, 8'hFC, 0, 1'b1);
        apply_stimulus(16, MODE_MULS, 16'h8000, 16'h8000, 8'h00, 64'h40000000, 8'h00, 0, 1'b1);

        for (int i = 0; i < 50 && (q8.size() + q16.size()) != 0; i++) @(negedge clk);
        check_output("scoreboard_drain", 64'(q8.size() + q16.size()), 64'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
